spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  Register bank directly downstream of the SPI register slave. Consumes its write strobe,
//  address and data; returns read data and an 8-bit status byte; executes 6-bit fast commands.
//  Holds RW config registers, a sticky W1C event register and a read-only ID register.
//  Sequences a timed soft reset of the config space.
// PARAMETERS
//  ADDR_W      3      register address width (>=2); bank has 2**ADDR_W registers
//  REG_W       8      register width, multiple of 8
//  CFG_RST     '0     reset/soft-reset value of every config register
//  ID_VAL      8'hA5  value of ID register (zero-extended to REG_W)
//  RST_CYCLES  4      soft_rst_o assertion length in clk cycles (>=1)
// PORTS
//  clk          in   1                 system clock
//  nrst         in   1                 asynchronous active-low reset
//  reg_addr     in   ADDR_W            register address from SPI slave
//  reg_wdata    in   REG_W             write data from SPI slave
//  reg_wvld     in   1                 1-cycle write strobe; reg_addr valid same cycle
//  reg_rdata    out  REG_W             read data for reg_addr (registered)
//  status       out  8                 status byte returned at start of each SPI frame
//  fastcmd      in   6                 fast command code
//  fastcmd_vld  in   1                 1-cycle fast command strobe
//  evt_i        in   REG_W             event inputs, any cycle high sets sticky bit
//  cfg_o        out  (2**ADDR_W-2)*REG_W  config regs, reg k at [k*REG_W +: REG_W]
//  irq_o        out  1                 |(evt_sticky & IRQ_MASK)
//  soft_rst_o   out  1                 high during soft-reset sequence
//  trig_o       out  1                 1-cycle trigger pulse
// BEHAVIOUR
//  Reset: clk single domain; nrst asynchronous active-low. All outputs and state 0 except
//   config regs = CFG_RST; FSM = IDLE.
//  Map: addr 0..N-3 config RW (N=2**ADDR_W); addr N-3 is also IRQ_MASK; addr N-2 EVT
//   (sticky, W1C); addr N-1 ID (RO, = ID_VAL).
//  Write (reg_wvld=1, FSM IDLE): config addr -> reg <= reg_wdata next edge; EVT addr ->
//   evt_sticky <= (evt_sticky & ~reg_wdata) | evt_i; ID addr -> no change, err <= 1.
//   Accepted writes (config/EVT) increment wr_cnt[3:0], wraps 15->0.
//  Write while FSM in SRST: discarded, err <= 1, wr_cnt unchanged.
//  Events: evt_sticky |= evt_i every cycle; set wins over simultaneous W1C clear.
//  Read: reg_rdata <= mux(reg_addr) every cycle; 1-cycle latency, no read side effects.
//   Reflects value after any same-cycle write one cycle later (i.e. 2 cycles from wvld).
//  status = {irq_o, err, soft_rst_o, 1'b0, wr_cnt[3:0]}, registered, 1-cycle latency.
//  Fast commands (on fastcmd_vld):
//   6'h00 NOP; 6'h01 soft reset; 6'h02 clear err and evt_sticky (evt_i same cycle still sets);
//   6'h03 trig_o=1 next cycle for exactly 1 cycle; any other code -> err <= 1.
//  FSM: IDLE --fastcmd 01--> SRST; SRST: soft_rst_o=1, counter counts RST_CYCLES cycles,
//   then config regs <= CFG_RST, wr_cnt <= 0, -> IDLE. soft_rst_o high exactly RST_CYCLES
//   cycles starting cycle after strobe. fastcmd 01 while SRST: ignored (no restart, no err).
//   Other fastcmds accepted in SRST. EVT and ID unaffected by soft reset.
//  Simultaneous reg_wvld and fastcmd_vld: both processed; soft reset does not cancel the
//   same-cycle write (write lands, then regs cleared at end of SRST).
//  nrst low mid-SRST: immediate return to reset state, soft_rst_o=0 asynchronously.
// TESTING
//  Write addr0=8'h3C -> cfg_o[7:0]==8'h3C, read addr0 reg_rdata==8'h3C, status[3:0]==1.
//  Pulse evt_i=8'h81 1 cycle, IRQ_MASK(addr5)=8'h01 -> irq_o=1; W1C 8'h01 to addr6 -> irq_o=0,
//   EVT reads 8'h80; W1C with evt_i[0] high same cycle -> bit0 stays set.
//  Write 8'hFF to addr7 -> ID still reads 8'hA5, status[6]=1; fastcmd 02 -> status[6]=0.
//  fastcmd 01 -> soft_rst_o high exactly 4 cycles, write during it dropped + err; after,
//   all cfg_o==0, wr_cnt==0, EVT preserved.
//  fastcmd 03 -> trig_o single 1-cycle pulse; fastcmd 3F -> err=1, no other effect.
//  Assert nrst mid-SRST -> soft_rst_o=0 at once, all regs at reset values, FSM IDLE.

Source files
------------

// File: rtl/spi_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank_if
// Description : Bus between the SPI register slave (master side) and the
//               register bank (slave side). Carries the register write
//               strobe/address/data, the fast-command strobe/code, and
//               returns registered read data plus the frame status byte.
// Ports       : reg_addr, reg_wdata, reg_wvld, fastcmd, fastcmd_vld
//               (master -> slave); reg_rdata, status (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_bank_if #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_wdata;
    logic              reg_wvld;
    logic [REG_W-1:0]  reg_rdata;
    logic [7:0]        status;
    logic [5:0]        fastcmd;
    logic              fastcmd_vld;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wvld,
        output fastcmd,
        output fastcmd_vld,
        input  reg_rdata,
        input  status
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wvld,
        input  fastcmd,
        input  fastcmd_vld,
        output reg_rdata,
        output status
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : Register bank behind the SPI register slave. Holds RW config
//               registers (the last one doubles as IRQ mask), a sticky W1C
//               event register and a read-only ID register. Executes 6-bit
//               fast commands and sequences a timed soft reset of the config
//               space.
// Ports       : clk         - system clock
//               nrst        - asynchronous active-low reset
//               bus         - slave side of spi_reg_bank_if (write strobe,
//                             address, data, fast command in; read data and
//                             status byte out, both registered)
//               evt_i       - event inputs, set sticky bits on any high cycle
//               cfg_o       - flattened config registers, reg k at
//                             [k*REG_W +: REG_W]
//               irq_o       - OR of masked sticky events
//               soft_rst_o  - high for RST_CYCLES cycles during soft reset
//               trig_o      - single-cycle trigger pulse
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank #(
    parameter int               ADDR_W     = 3,
    parameter int               REG_W      = 8,
    parameter logic [REG_W-1:0] CFG_RST    = '0,
    parameter logic [7:0]       ID_VAL     = 8'hA5,
    parameter int               RST_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               nrst,
    spi_reg_bank_if.slave                      bus,
    input  logic [REG_W-1:0]                   evt_i,
    output logic [(2**ADDR_W-2)*REG_W-1:0]     cfg_o,
    output logic                               irq_o,
    output logic                               soft_rst_o,
    output logic                               trig_o
);

    localparam int c_num_regs = 2 ** ADDR_W;
    localparam int c_num_cfg  = c_num_regs - 2;
    localparam logic [ADDR_W-1:0] c_evt_addr = ADDR_W'(c_num_cfg);
    localparam logic [ADDR_W-1:0] c_id_addr  = ADDR_W'(c_num_cfg + 1);
    localparam int c_cnt_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RST_CYCLES - 1);

    localparam logic [5:0] c_fc_nop  = 6'h00;
    localparam logic [5:0] c_fc_srst = 6'h01;
    localparam logic [5:0] c_fc_clr  = 6'h02;
    localparam logic [5:0] c_fc_trig = 6'h03;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SRST = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_soft_rst;
    logic [REG_W-1:0]     r_cfg [c_num_cfg];
    logic [REG_W-1:0]     r_evt;
    logic                 r_err;
    logic [3:0]           r_wr_cnt;
    logic                 r_trig;
    logic [REG_W-1:0]     r_rdata;
    logic [7:0]           r_status;

    logic                 w_idle;
    logic                 w_hit_evt;
    logic                 w_hit_id;
    logic                 w_wr_acc;
    logic                 w_wr_cfg;
    logic                 w_wr_evt;
    logic                 w_fc_srst;
    logic                 w_fc_clr;
    logic                 w_fc_trig;
    logic                 w_fc_bad;
    logic                 w_err_set;
    logic                 w_srst_done;
    logic                 w_irq;
    logic [REG_W-1:0]     w_rd_mux;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_hit_evt = (bus.reg_addr == c_evt_addr);
    assign w_hit_id  = (bus.reg_addr == c_id_addr);

    // Writes land only while idle; the ID register never accepts one.
    assign w_wr_acc  = bus.reg_wvld && w_idle && !w_hit_id;
    assign w_wr_cfg  = w_wr_acc && !w_hit_evt;
    assign w_wr_evt  = w_wr_acc && w_hit_evt;

    assign w_fc_srst = bus.fastcmd_vld && (bus.fastcmd == c_fc_srst);
    assign w_fc_clr  = bus.fastcmd_vld && (bus.fastcmd == c_fc_clr);
    assign w_fc_trig = bus.fastcmd_vld && (bus.fastcmd == c_fc_trig);
    assign w_fc_bad  = bus.fastcmd_vld && (bus.fastcmd > c_fc_trig);

    // A dropped write (SRST or ID target) and an unknown command both flag
    // an error; setting has priority over a same-cycle clear command.
    assign w_err_set = (bus.reg_wvld && (!w_idle || w_hit_id)) || w_fc_bad;

    assign w_srst_done = (r_state == ST_SRST) && (r_cnt == c_cnt_last);
    assign w_irq       = |(r_evt & r_cfg[c_num_cfg-1]);

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_evt) begin
            w_rd_mux = r_evt;
        end else if (w_hit_id) begin
            w_rd_mux = REG_W'(ID_VAL);
        end else begin
            for (int k = 0; k < c_num_cfg; k++) begin
                if (bus.reg_addr == ADDR_W'(k)) begin
                    w_rd_mux = r_cfg[k];
                end
            end
        end
    end

    // Soft-reset sequencer. soft_rst is registered so it rises the cycle
    // after the strobe and stays high for exactly RST_CYCLES cycles. A new
    // soft-reset command during the sequence is ignored (no restart).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fc_srst) begin
                        r_state    <= ST_SRST;
                        r_cnt      <= '0;
                        r_soft_rst <= 1'b1;
                    end
                end
                ST_SRST: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_soft_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    r_soft_rst <= 1'b0;
                end
            endcase
        end
    end

    // Config space and write counter. Writes are never accepted in SRST, so
    // the end-of-sequence clear cannot collide with a write.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < c_num_cfg; k++) begin
                r_cfg[k] <= CFG_RST;
            end
            r_wr_cnt <= 4'd0;
        end else if (w_srst_done) begin
            for (int k = 0; k < c_num_cfg; k++) begin
                r_cfg[k] <= CFG_RST;
            end
            r_wr_cnt <= 4'd0;
        end else begin
            for (int k = 0; k < c_num_cfg; k++) begin
                if (w_wr_cfg && (bus.reg_addr == ADDR_W'(k))) begin
                    r_cfg[k] <= bus.reg_wdata;
                end
            end
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + 4'd1;
            end
        end
    end

    // Events, error flag, trigger and the registered read/status returns.
    // New events are OR-ed in last so they win over W1C and clear command.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_evt    <= '0;
            r_err    <= 1'b0;
            r_trig   <= 1'b0;
            r_rdata  <= '0;
            r_status <= 8'd0;
        end else begin
            r_evt    <= ((w_fc_clr ? '0 : r_evt) & ~(w_wr_evt ? bus.reg_wdata : '0)) | evt_i;
            r_err    <= w_err_set ? 1'b1 : (w_fc_clr ? 1'b0 : r_err);
            r_trig   <= w_fc_trig;
            r_rdata  <= w_rd_mux;
            r_status <= {w_irq, r_err, r_soft_rst, 1'b0, r_wr_cnt};
        end
    end

    generate
        for (genvar g = 0; g < c_num_cfg; g++) begin : g_cfg_out
            assign cfg_o[g*REG_W +: REG_W] = r_cfg[g];
        end
    endgenerate

    assign bus.reg_rdata = r_rdata;
    assign bus.status    = r_status;
    assign irq_o         = w_irq;
    assign soft_rst_o    = r_soft_rst;
    assign trig_o        = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bank
// Description : Self-checking bench for spi_reg_bank. A behavioural model of
//               the register map is advanced once per clock from the driven
//               inputs; a negedge compare process checks every output against
//               it. Directed scenarios add literal expectations, followed by
//               a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    localparam int ADDR_W = 3;
    localparam int REG_W  = 8;
    localparam int NCFG   = 6;
    localparam int RSTC   = 4;

    logic        clk  = 1'b0;
    logic        nrst = 1'b1;
    logic [7:0]  evt_i = 8'h00;
    logic [47:0] cfg_o;
    logic        irq_o;
    logic        soft_rst_o;
    logic        trig_o;

    spi_reg_bank_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    spi_reg_bank #(
        .ADDR_W     (ADDR_W),
        .REG_W      (REG_W),
        .CFG_RST    (8'h00),
        .ID_VAL     (8'hA5),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (bus.slave),
        .evt_i      (evt_i),
        .cfg_o      (cfg_o),
        .irq_o      (irq_o),
        .soft_rst_o (soft_rst_o),
        .trig_o     (trig_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: register values plus remaining soft-reset cycles
    // ------------------------------------------------------------------
    logic [7:0] m_cfg [NCFG];
    logic [7:0] m_evt;
    logic [7:0] m_rdata;
    logic [7:0] m_status;
    logic       m_err;
    logic       m_trig;
    int         m_wrcnt;
    int         m_left;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;
    int  n_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < NCFG)  return m_cfg[a];
        if (a == NCFG) return m_evt;
        return 8'hA5;
    endfunction

    function automatic logic m_irq();
        return |(m_evt & m_cfg[NCFG-1]);
    endfunction

    function automatic logic [47:0] m_cfg_flat();
        logic [47:0] f;
        f = '0;
        for (int k = 0; k < NCFG; k++) f[k*8 +: 8] = m_cfg[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCFG; k++) m_cfg[k] = 8'h00;
        m_evt    = 8'h00;
        m_rdata  = 8'h00;
        m_status = 8'h00;
        m_err    = 1'b0;
        m_trig   = 1'b0;
        m_wrcnt  = 0;
        m_left   = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs held at that edge.
    task automatic model_step();
        bit         in_srst;
        int         a;
        logic [7:0] nxt_rd;
        logic [7:0] nxt_st;
        in_srst = (m_left > 0);
        a       = int'(bus.reg_addr);
        nxt_rd  = m_read(a);
        nxt_st  = {m_irq(), m_err, in_srst, 1'b0, 4'(m_wrcnt)};
        m_trig  = bus.fastcmd_vld && (bus.fastcmd == 6'h03);
        if (bus.fastcmd_vld) begin
            case (bus.fastcmd)
                6'h00: ;
                6'h01: if (!in_srst) m_left = RSTC;
                6'h02: begin m_err = 1'b0; m_evt = 8'h00; end
                6'h03: ;
                default: m_err = 1'b1;
            endcase
        end
        if (bus.reg_wvld) begin
            if (in_srst || a == NCFG + 1) begin
                m_err = 1'b1;
            end else begin
                if (a == NCFG) m_evt = m_evt & ~bus.reg_wdata;
                else           m_cfg[a] = bus.reg_wdata;
                m_wrcnt = (m_wrcnt + 1) % 16;
            end
        end
        m_evt = m_evt | evt_i;
        if (in_srst) begin
            m_left--;
            if (m_left == 0) begin
                for (int k = 0; k < NCFG; k++) m_cfg[k] = 8'h00;
                m_wrcnt = 0;
            end
        end
        m_rdata  = nxt_rd;
        m_status = nxt_st;
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata",    64'(bus.reg_rdata), 64'(m_rdata));
            chk("status",   64'(bus.status),    64'(m_status));
            chk("cfg_o",    64'(cfg_o),         64'(m_cfg_flat()));
            chk("irq_o",    64'(irq_o),         64'(m_irq()));
            chk("soft_rst", 64'(soft_rst_o),    64'(m_left > 0));
            chk("trig_o",   64'(trig_o),        64'(m_trig));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (nrst) model_step();
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.reg_addr  = 3'(a);
        bus.reg_wdata = d;
        bus.reg_wvld  = 1'b1;
        tick();
        bus.reg_wvld  = 1'b0;
    endtask

    task automatic fc(input logic [5:0] code);
        bus.fastcmd     = code;
        bus.fastcmd_vld = 1'b1;
        tick();
        bus.fastcmd_vld = 1'b0;
    endtask

    task automatic rd(input int a);
        bus.reg_addr = 3'(a);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: simulation bound exceeded");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.reg_addr    = '0;
        bus.reg_wdata   = '0;
        bus.reg_wvld    = 1'b0;
        bus.fastcmd     = '0;
        bus.fastcmd_vld = 1'b0;
        model_reset();
        #1 nrst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        chk("rst_status", 64'(bus.status), 64'h00);
        chk("rst_cfg",    64'(cfg_o),      64'h0);
        chk("rst_rdata",  64'(bus.reg_rdata), 64'h00);

        // Basic config write and read-back
        wr(0, 8'h3C);
        bus.reg_addr = 3'd0;
        tick();
        chk("w0_cfg",  64'(cfg_o[7:0]),       64'h3C);
        chk("w0_rd",   64'(bus.reg_rdata),    64'h3C);
        chk("w0_cnt",  64'(bus.status[3:0]),  64'h1);

        // Sticky events, mask, W1C, set-beats-clear
        evt_i = 8'h81;
        tick();
        evt_i = 8'h00;
        wr(5, 8'h01);
        chk("irq_set", 64'(irq_o), 64'h1);
        wr(6, 8'h01);
        chk("irq_clr", 64'(irq_o), 64'h0);
        rd(6);
        chk("evt_w1c", 64'(bus.reg_rdata), 64'h80);
        evt_i = 8'h01;
        wr(6, 8'h01);
        evt_i = 8'h00;
        rd(6);
        chk("evt_setwin", 64'(bus.reg_rdata), 64'h81);

        // ID read-only, error flag, clear command
        wr(7, 8'hFF);
        rd(7);
        chk("id_ro",   64'(bus.reg_rdata), 64'hA5);
        chk("id_err",  64'(bus.status[6]), 64'h1);
        fc(6'h02);
        tick();
        chk("err_clr", 64'(bus.status[6]), 64'h0);

        // Soft reset length, dropped write, preserved EVT
        evt_i = 8'h10;
        tick();
        evt_i = 8'h00;
        wr(1, 8'h5A);
        fc(6'h01);
        n_cnt = int'(soft_rst_o);
        wr(2, 8'h99);
        n_cnt += int'(soft_rst_o);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cnt += int'(soft_rst_o);
        end
        chk("srst_len", 64'(n_cnt), 64'd4);
        chk("srst_cfg", 64'(cfg_o), 64'h0);
        chk("srst_cnt", 64'(bus.status[3:0]), 64'h0);
        chk("srst_err", 64'(bus.status[6]), 64'h1);
        rd(6);
        chk("srst_evt", 64'(bus.reg_rdata), 64'h10);

        // Trigger pulse and unknown command
        fc(6'h02);
        wr(1, 8'h42);
        fc(6'h03);
        n_cnt = int'(trig_o);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cnt += int'(trig_o);
        end
        chk("trig_len", 64'(n_cnt), 64'd1);
        fc(6'h3F);
        tick();
        chk("bad_err",  64'(bus.status[6]), 64'h1);
        chk("bad_cfg",  64'(cfg_o[15:8]),   64'h42);
        chk("bad_cnt",  64'(bus.status[3:0]), 64'h1);
        chk("bad_srst", 64'(soft_rst_o), 64'h0);

        // Asynchronous reset in the middle of a soft reset
        wr(0, 8'h77);
        fc(6'h01);
        tick();
        nrst = 1'b0;
        #1;
        chk("arst_srst",   64'(soft_rst_o), 64'h0);
        chk("arst_cfg",    64'(cfg_o),      64'h0);
        chk("arst_status", 64'(bus.status), 64'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        wr(0, 8'h11);
        chk("arst_idle", 64'(cfg_o[7:0]), 64'h11);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            bus.reg_addr    = 3'($urandom);
            bus.reg_wdata   = 8'($urandom);
            bus.reg_wvld    = ($urandom_range(0, 9) < 3);
            bus.fastcmd_vld = ($urandom_range(0, 9) == 0);
            bus.fastcmd     = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                                          : 6'($urandom_range(0, 3));
            evt_i           = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom)
                                                          : 8'h00;
            tick();
        end
        bus.reg_wvld    = 1'b0;
        bus.fastcmd_vld = 1'b0;
        evt_i           = 8'h00;
        repeat (RSTC + 3) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
